mod_counter: RTL



---
 rtl/mod_counter_if.sv | 17 +
 rtl/mod_counter.sv | 72 +++++++
 2 files changed

// File: rtl/mod_counter_if.sv
// Control/status bundle between a controller FSM (master) and one mod_counter (slave).
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             init;
  logic             ld;
  logic             en;
  logic             dn;
  logic [WIDTH-1:0] prl;
  logic [WIDTH-1:0] out;
  logic             Co;
  logic             wrap;
  logic             ovf;

  modport master (output init, ld, en, dn, prl, input out, Co, wrap, ovf);
  modport slave  (input init, ld, en, dn, prl, output out, Co, wrap, ovf);
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up/down counter with clamp-on-load, terminal count, wrap pulse and sticky overflow.
// Define COUNTER_SAT_EN for saturating terminal steps (wrap tied low).
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic          clk,
  input  logic          rst,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0]  LAST  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
  localparam int unsigned       MOD_U = MOD;

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic             r_ovf;

  logic w_at_top;
  logic w_at_zero;
  logic w_term;
  logic w_prl_ok;

  // Explicit end-of-range compares so MOD == 2^WIDTH never relies on overflow.
  assign w_at_top  = (r_out == LAST);
  assign w_at_zero = (r_out == '0);
  assign w_term    = bus.dn ? w_at_zero : w_at_top;
  assign w_prl_ok  = (32'(bus.prl) < MOD_U);

  assign bus.out  = r_out;
  assign bus.Co   = w_term;
  assign bus.wrap = r_wrap;
  assign bus.ovf  = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.init) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.ld) begin
      r_wrap <= 1'b0;
      if (w_prl_ok) begin
        r_out <= bus.prl;
        r_ovf <= 1'b0;
      end else begin
        r_out <= LAST;
        r_ovf <= 1'b1;
      end
    end else if (bus.en) begin
      if (w_term) begin
        r_ovf <= 1'b1;
`ifdef COUNTER_SAT_EN
        r_wrap <= 1'b0;
`else
        r_wrap <= 1'b1;
        r_out  <= bus.dn ? LAST : '0;
`endif
      end else begin
        r_wrap <= 1'b0;
        r_out  <= bus.dn ? (r_out - ONE) : (r_out + ONE);
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

endmodule
